// File: rtl/fb_pkg.sv
// Shared constants, state encoding and write-buffer entry type for the
// frame-buffer arbiter slice.
package fb_pkg;

  localparam int H_PIX      = 200;
  localparam int V_PIX      = 150;
  localparam int FB_WORDS   = H_PIX * V_PIX;
  localparam int ADDR_W     = 15;
  localparam int DATA_W     = 4;
  localparam int WBUF_DEPTH = 4;

  // First out-of-range address and last valid address, at RAM address width.
  localparam logic [ADDR_W-1:0] FB_LIMIT = ADDR_W'(FB_WORDS);
  localparam logic [ADDR_W-1:0] FB_LAST  = ADDR_W'(FB_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } fb_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wbuf_entry_t;

  // True when an address lies inside the 200x150 frame buffer.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
    return addr < FB_LIMIT;
  endfunction

endpackage

// File: rtl/fb_wbuf.sv
// Small synchronous FIFO holding host pixel writes until the RAM port has
// a free slot. Pointers carry one extra wrap bit to tell full from empty.
module fb_wbuf
  import fb_pkg::*;
#(
  parameter int DEPTH = WBUF_DEPTH
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_push,
  input  wbuf_entry_t i_push_entry,
  input  logic        i_pop,
  output wbuf_entry_t o_head,
  output logic        o_full,
  output logic        o_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  wbuf_entry_t      mem_q [DEPTH];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic             do_push;
  logic             do_pop;

  assign o_empty = (wr_ptr_q == rd_ptr_q);
  assign o_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign o_head  = mem_q[rd_ptr_q[PTR_W-1:0]];

  // Guard the handshakes locally so a stray request can never corrupt the pointers.
  assign do_push = i_push && !o_full;
  assign do_pop  = i_pop && !o_empty;

  // Next-state pointer arithmetic.
  always_comb begin
    // NOTE: defaults first so every path assigns the outputs and no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers; reset empties the buffer.
  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: non-blocking assignments so all registers sample pre-edge values.
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage written on accepted pushes.
  always_ff @(posedge i_clk) begin
    // NOTE: storage is not reset; the pointers alone decide which entries are live.
    if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= i_push_entry;
  end

endmodule

// File: rtl/fb_arbiter.sv
// Single-port frame-buffer arbiter: scan-out reads have absolute priority,
// then the clear engine, then the host write buffer. RAM-side outputs are
// combinational from registered state plus the scan request/address.
module fb_arbiter
  import fb_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_scan_req,
  input  logic [ADDR_W-1:0] i_scan_addr,
  output logic [DATA_W-1:0] o_scan_data,
  output logic              o_scan_valid,
  input  logic              i_wr_valid,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ready,
  input  logic              i_clr_start,
  input  logic [DATA_W-1:0] i_clr_color,
  output logic              o_clr_busy,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic              o_ram_we,
  output logic [DATA_W-1:0] o_ram_wdata,
  input  logic [DATA_W-1:0] i_ram_rdata
);

  fb_state_e         state_q, state_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [DATA_W-1:0] color_q, color_d;

  // Scan return pipeline: stage 1 tracks the outstanding RAM read.
  logic              scan_p1_q;
  logic              scan_oob_p1_q;
  logic              scan_valid_q;
  logic [DATA_W-1:0] scan_data_q, scan_data_d;

  wbuf_entry_t       wbuf_head;
  wbuf_entry_t       wbuf_push_entry;
  logic              wbuf_push;
  logic              wbuf_pop;
  logic              wbuf_full;
  logic              wbuf_empty;

  // The host may only enqueue while no clear sequence is pending.
  assign o_wr_ready      = !wbuf_full && (state_q == IDLE);
  assign o_clr_busy      = (state_q != IDLE);
  assign wbuf_push       = i_wr_valid && o_wr_ready;
  assign wbuf_push_entry = '{addr: i_wr_addr, data: i_wr_data};

  fb_wbuf #(
    .DEPTH(WBUF_DEPTH)
  ) u_wbuf (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (wbuf_push),
    .i_push_entry(wbuf_push_entry),
    .i_pop       (wbuf_pop),
    .o_head      (wbuf_head),
    .o_full      (wbuf_full),
    .o_empty     (wbuf_empty)
  );

  // Slot arbitration: scan, then clear, then the write-buffer head, else idle.
  always_comb begin
    o_ram_addr  = '0;
    o_ram_we    = 1'b0;
    o_ram_wdata = '0;
    wbuf_pop    = 1'b0;
    if (i_scan_req) begin
      o_ram_addr = i_scan_addr;
    end else if (state_q == CLEAR) begin
      o_ram_addr  = count_q;
      o_ram_we    = 1'b1;
      o_ram_wdata = color_q;
    end else if (!wbuf_empty) begin
      // Out-of-range entries still consume the slot but are discarded.
      wbuf_pop = 1'b1;
      if (addr_in_range(wbuf_head.addr)) begin
        o_ram_addr  = wbuf_head.addr;
        o_ram_we    = 1'b1;
        o_ram_wdata = wbuf_head.data;
      end
    end
  end

  // Clear-sequence next state: drain pending host writes, then fill every word.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    color_d = color_q;
    unique case (state_q)
      IDLE: begin
        if (i_clr_start) begin
          color_d = i_clr_color;
          count_d = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Checked on entry too, so an already-empty buffer costs one cycle.
        if (wbuf_empty) state_d = CLEAR;
      end
      CLEAR: begin
        // Scan-stolen slots simply postpone the current address.
        if (!i_scan_req) begin
          if (count_q == FB_LAST) state_d = IDLE;
          else                    count_d = count_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Clear-sequence registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      count_q <= '0;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      color_q <= color_d;
    end
  end

  // Returned read data, forced to zero for addresses outside the frame.
  always_comb begin
    scan_data_d = scan_data_q;
    if (scan_p1_q) scan_data_d = scan_oob_p1_q ? '0 : i_ram_rdata;
  end

  // Two-stage scan return pipeline giving a fixed latency of two cycles.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      scan_p1_q     <= 1'b0;
      scan_oob_p1_q <= 1'b0;
      scan_valid_q  <= 1'b0;
      scan_data_q   <= '0;
    end else begin
      scan_p1_q     <= i_scan_req;
      scan_oob_p1_q <= i_scan_req && !addr_in_range(i_scan_addr);
      scan_valid_q  <= scan_p1_q;
      scan_data_q   <= scan_data_d;
    end
  end

  assign o_scan_valid = scan_valid_q;
  assign o_scan_data  = scan_data_q;

endmodule
